// File: rtl/div_table_loader.sv
// div_table_loader: generates the zero-crossing interpolator's reciprocal table.
// Entry i = min(floor(NUMERATOR / i), 2^WIDTH-1). A restoring divider produces one
// quotient bit per cycle, so no ROM or hard divider is needed. The block also drives
// the interpolator's run line. A one-cycle pulse in SYNC clears the interpolator's
// write pointer. Run stays low while the table loads and goes high once it is complete.
module div_table_loader #(
   parameter int DEPTH     = 2048,
   parameter int WIDTH     = 11,
   parameter int NUMERATOR = 2048,
   parameter int NUM_BITS  = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             run,
   output logic             div_table_wr_en,
   output logic [WIDTH-1:0] div_table_wr_data,
   output logic             busy,
   output logic             done,
   output logic             loaded,
   output logic [WIDTH-1:0] index
);

   localparam int RW = NUM_BITS + 1;
   localparam int CW = $clog2(NUM_BITS);
   localparam logic [NUM_BITS-1:0] NUM_VEC = NUM_BITS'(NUMERATOR);
   localparam logic [WIDTH-1:0]    SAT     = '1;
   localparam logic [WIDTH-1:0]    LAST    = WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DIV, S_WRITE, S_FIN} state_t;

   state_t              state_q, state_d;
   logic                run_q, run_d;
   logic                wr_en_q, wr_en_d;
   logic [WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                loaded_q, loaded_d;
   logic [WIDTH-1:0]    index_q, index_d;
   logic [RW-1:0]       rem_q, rem_d;
   logic [NUM_BITS-1:0] quo_q, quo_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [CW-1:0]       bit_sel;
   logic [RW-1:0]       divisor;
   logic [RW-1:0]       rem_shift;
   logic                q_bit;
   logic [NUM_BITS-1:0] quo_next;
   logic [WIDTH-1:0]    quo_sat;

   // Next-state, divider step and registered-output values for every state.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
      state_d   = state_q;
      run_d     = run_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      loaded_d  = loaded_q;
      index_d   = index_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;

      // Dividend bits are consumed MSB first. The divisor is the entry index.
      bit_sel   = CW'(NUM_BITS - 1) - cnt_q;
      divisor   = RW'(index_q);
      rem_shift = RW'({rem_q, NUM_VEC[bit_sel]});
      q_bit     = (rem_shift >= divisor);
      quo_next  = NUM_BITS'({quo_q, q_bit});
      quo_sat   = (quo_next > NUM_BITS'(SAT)) ? SAT : quo_next[WIDTH-1:0];

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_SYNC;
               run_d    = 1'b1;
               busy_d   = 1'b1;
               loaded_d = 1'b0;
               index_d  = '0;
            end
         end
         S_SYNC: begin
            state_d = S_DIV;
            run_d   = 1'b0;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
         end
         S_DIV: begin
            rem_d = q_bit ? (rem_shift - divisor) : rem_shift;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NUM_BITS - 1)) begin
               state_d   = S_WRITE;
               wr_en_d   = 1'b1;
               wr_data_d = quo_sat;
            end
         end
         S_WRITE: begin
            if (index_q == LAST) begin
               state_d = S_FIN;
               busy_d  = 1'b0;
            end else begin
               state_d = S_DIV;
               index_d = index_q + 1'b1;
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = '0;
            end
         end
         S_FIN: begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            run_d    = 1'b1;
            loaded_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers. A low reset clears all of them immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         run_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         loaded_q  <= 1'b0;
         index_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples pre-edge values.
         state_q   <= state_d;
         run_q     <= run_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         loaded_q  <= loaded_d;
         index_q   <= index_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
      end
   end

   assign run               = run_q;
   assign div_table_wr_en   = wr_en_q;
   assign div_table_wr_data = wr_data_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign loaded            = loaded_q;
   assign index             = index_q;

endmodule

// File: tb/tb_div_table_loader.sv
// Self-checking bench for div_table_loader. Expected table entries come from plain
// integer division. Expected timing comes from a cycle count measured from the SYNC
// cycle: one write every NUM_BITS+1 cycles, then FIN, then the done cycle.
module tb_div_table_loader;

   localparam int DEPTH     = 2048;
   localparam int WIDTH     = 11;
   localparam int NUMERATOR = 2048;
   localparam int NUM_BITS  = 12;
   localparam int SAT       = (1 << WIDTH) - 1;
   localparam int PERIOD    = NUM_BITS + 1;
   localparam int LOAD_CYC  = PERIOD * DEPTH + 2;

   logic             clk;
   logic             reset;
   logic             start;
   logic             run;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic             loaded;
   logic [WIDTH-1:0] index;

   int n_checks = 0;
   int n_errors = 0;

   div_table_loader #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .NUMERATOR(NUMERATOR), .NUM_BITS(NUM_BITS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .run(run),
      .div_table_wr_en(wr_en), .div_table_wr_data(wr_data),
      .busy(busy), .done(done), .loaded(loaded), .index(index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference entry: integer division, saturated to WIDTH bits. Divisor 0 saturates.
   function automatic int exp_entry(input int i);
      int q;
      if (i == 0) return SAT;
      q = NUMERATOR / i;
      return (q > SAT) ? SAT : q;
   endfunction

   // Known spot values at the default parameters. Returns -1 for other indices.
   function automatic int spot_entry(input int i);
      case (i)
         0:       return 2047;
         1:       return 2047;
         2:       return 1024;
         3:       return 682;
         2047:    return 1;
         default: return -1;
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check(tag, {run, wr_en, wr_data, busy, done, loaded, index}, 32'd0);
   endtask

   // Idle for n cycles. Only run and loaded may be high.
   task automatic idle_cycles(input int n, input bit exp_run, input bit exp_loaded);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("idle_flags", {run, wr_en, busy, done, loaded}, {exp_run, 1'b0, 1'b0, 1'b0, exp_loaded});
      end
   endtask

   // Follows one load from its SYNC cycle. If abort_at >= 0, reset is asserted
   // right after the write of that index.
   task automatic do_load(input bit hold_start, input int abort_at);
      int  nw;
      int  idx;
      int  exp_idx;
      int  spot;
      bit  exp_we, exp_busy, exp_fin;
      @(negedge clk);
      check("sync_flags", {run, wr_en, busy, done, loaded}, 5'b10100);
      check("sync_index", index, 0);
      if (!hold_start) start = 1'b0;
      nw = 0;
      for (int c = 1; c <= LOAD_CYC; c++) begin
         @(negedge clk);
         exp_we   = (c % PERIOD == 0) && (c / PERIOD <= DEPTH);
         exp_busy = (c <= PERIOD * DEPTH);
         exp_fin  = (c == LOAD_CYC);
         exp_idx  = exp_busy ? (c - 1) / PERIOD : DEPTH - 1;
         check("flags", {run, wr_en, busy, done, loaded}, {exp_fin, exp_we, exp_busy, exp_fin, exp_fin});
         check("index", index, exp_idx);
         if (exp_we) begin
            idx = c / PERIOD - 1;
            check("wr_data", wr_data, exp_entry(idx));
            spot = spot_entry(idx);
            if (spot >= 0) check("wr_data_spot", wr_data, spot);
            nw++;
            if (idx == abort_at) begin
               reset = 1'b0;
               #1;
               check_all_zero("async_reset");
               return;
            end
         end
      end
      check("write_count", nw, DEPTH);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_values");
      reset = 1'b1;
      idle_cycles($urandom_range(2, 10), 1'b0, 1'b0);

      // Load 1: start is held high for the whole load. No restart is expected.
      start = 1'b1;
      do_load(1'b1, -1);

      // Start is still high, so load 2 begins at once. It is aborted by reset at write 700.
      do_load(1'b0, 700);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_all_zero("reset_hold");
      end
      reset = 1'b1;
      idle_cycles($urandom_range(3, 20), 1'b0, 1'b0);

      // Load 3: a single-cycle start pulse, then the table is rewritten from index 0.
      start = 1'b1;
      do_load(1'b0, -1);
      idle_cycles($urandom_range(3, 20), 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
